// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - Kabeta Beta PC register, PC+4 pipeline and IF invalid-address exception
// Optional feature macro: PC_SUPERVISOR_BIT_EN (PC[31] acts as the supervisor bit)
module pc_unit #(
  parameter int IMEM_WORDS = 4096
) (
  input  logic        Clock,
  input  logic        SysReset,
  input  logic [1:0]  PC_Sel,
  input  logic [31:0] ExcAddr,
  input  logic        Stall,
  input  logic        ReplicatePC,
  input  logic [31:0] Ra,
  input  logic [15:0] Lit,
  input  logic        ExcAckIF,
  output logic [31:0] IA,
  output logic [31:0] PCInc_RR,
  output logic [31:0] PCInc_EX,
  output logic [31:0] PCInc_MA,
  output logic        ExcReqIF,
  output logic [2:0]  ExcCodeIF,
  output logic        S_Mode
);

  localparam logic [1:0]  PCS_PCNX  = 2'd0;
  localparam logic [1:0]  PCS_PCLIT = 2'd1;
  localparam logic [1:0]  PCS_REGA  = 2'd2;
  localparam logic [1:0]  PCS_EXCA  = 2'd3;
  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);
`ifdef PC_SUPERVISOR_BIT_EN
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
`else
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`endif

  logic [31:0] pcReg;
  logic [31:0] pcInc;
  logic [31:0] litOffset;
  logic [31:0] branchSum;
  logic [31:0] branchTarget;
  logic [31:0] jumpTarget;
  logic [31:0] nextPc;
  logic        loadPc;
  logic        loadRr;
  logic        nextInvalid;

  always_comb begin
    litOffset = {{14{Lit[15]}}, Lit, 2'b00};
    branchSum = PCInc_RR + litOffset;
`ifdef PC_SUPERVISOR_BIT_EN
    // The supervisor bit never changes through increment, branch or a user JMP.
    pcInc        = {pcReg[31], pcReg[30:0] + 31'd4};
    branchTarget = {PCInc_RR[31], 31'b0} | (branchSum & 32'h7FFF_FFFF);
    jumpTarget   = {Ra[31] & PCInc_RR[31], 31'b0} | (Ra & 32'h7FFF_FFFC);
`else
    pcInc        = pcReg + 32'd4;
    branchTarget = branchSum;
    jumpTarget   = Ra & 32'hFFFF_FFFC;
`endif
  end

  always_comb begin
    nextPc = pcReg;
    loadPc = 1'b0;
    loadRr = 1'b0;
    if (PC_Sel == PCS_EXCA) begin
      nextPc = ExcAddr;
      loadPc = 1'b1;
      loadRr = !Stall;
    end else if (!Stall) begin
      loadPc = 1'b1;
      loadRr = !ReplicatePC;
      case (PC_Sel)
        PCS_PCLIT: nextPc = branchTarget;
        PCS_REGA:  nextPc = jumpTarget;
        default:   nextPc = pcInc;
      endcase
    end
  end

  always_comb begin
`ifdef PC_SUPERVISOR_BIT_EN
    nextInvalid = (nextPc[1:0] != 2'b00) || ({3'b000, nextPc[30:2]} >= IMEM_LIMIT);
`else
    nextInvalid = (nextPc[1:0] != 2'b00) || ({2'b00, nextPc[31:2]} >= IMEM_LIMIT);
`endif
  end

  always_ff @(posedge Clock) begin
    if (!SysReset) begin
      pcReg    <= RESET_PC;
      PCInc_RR <= 32'h0;
      PCInc_EX <= 32'h0;
      PCInc_MA <= 32'h0;
      ExcReqIF <= 1'b0;
    end else begin
      if (loadPc) pcReg <= nextPc;
      if (loadRr) PCInc_RR <= pcInc;
      // EX/MA always advance so stall bubbles still carry a usable link address.
      PCInc_EX <= PCInc_RR;
      PCInc_MA <= PCInc_EX;
      if (loadPc) ExcReqIF <= nextInvalid;
      else if (ExcAckIF) ExcReqIF <= 1'b0;
    end
  end

  assign IA        = pcReg;
  assign ExcCodeIF = 3'b000;
`ifdef PC_SUPERVISOR_BIT_EN
  assign S_Mode = pcReg[31];
`else
  assign S_Mode = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - scoreboard bench for pc_unit (honours PC_SUPERVISOR_BIT_EN)
module tb_pc_unit;
  localparam int IMEM = 4096;
  localparam logic [1:0] NX = 2'd0, LT = 2'd1, RG = 2'd2, EX = 2'd3;

  logic        Clock = 1'b0;
  logic        SysReset = 1'b0;
  logic [1:0]  PC_Sel = EX;
  logic [31:0] ExcAddr = 32'h0;
  logic        Stall = 1'b0;
  logic        ReplicatePC = 1'b0;
  logic [31:0] Ra = 32'h0;
  logic [15:0] Lit = 16'h0;
  logic        ExcAckIF = 1'b0;
  logic [31:0] IA, PCInc_RR, PCInc_EX, PCInc_MA;
  logic        ExcReqIF, S_Mode;
  logic [2:0]  ExcCodeIF;

  pc_unit #(.IMEM_WORDS(IMEM)) dut (
    .Clock(Clock), .SysReset(SysReset), .PC_Sel(PC_Sel), .ExcAddr(ExcAddr),
    .Stall(Stall), .ReplicatePC(ReplicatePC), .Ra(Ra), .Lit(Lit), .ExcAckIF(ExcAckIF),
    .IA(IA), .PCInc_RR(PCInc_RR), .PCInc_EX(PCInc_EX), .PCInc_MA(PCInc_MA),
    .ExcReqIF(ExcReqIF), .ExcCodeIF(ExcCodeIF), .S_Mode(S_Mode)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] pc, rr, ex, ma;
    logic        req, smode;
  } exp_t;

  exp_t expQ[$];
  int total = 0;
  int bad = 0;
  logic [31:0] mPc = 32'h0, mRr = 32'h0, mEx = 32'h0, mMa = 32'h0;
  logic        mReq = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] inc4(input logic [31:0] p);
`ifdef PC_SUPERVISOR_BIT_EN
    return {p[31], p[30:0] + 31'd4};
`else
    return p + 32'd4;
`endif
  endfunction

  function automatic logic badAddr(input logic [31:0] p);
    logic [31:0] word;
`ifdef PC_SUPERVISOR_BIT_EN
    word = {3'b000, p[30:2]};
`else
    word = {2'b00, p[31:2]};
`endif
    return (p[1:0] != 2'b00) || (word >= 32'(IMEM));
  endfunction

  function automatic logic [31:0] litTarget(input logic [31:0] rr, input logic [15:0] l);
    logic [31:0] s;
    s = rr + ({{16{l[15]}}, l} << 2);
`ifdef PC_SUPERVISOR_BIT_EN
    s[31] = rr[31];
`endif
    return s;
  endfunction

  function automatic logic [31:0] jmpTarget(input logic [31:0] rr, input logic [31:0] r);
    logic [31:0] t;
    t = {r[31:2], 2'b00};
`ifdef PC_SUPERVISOR_BIT_EN
    t[31] = r[31] & rr[31];
`endif
    return t;
  endfunction

  // Driver: apply one cycle of inputs, advance the reference model, queue the expectation.
  task automatic step(input logic rst, input logic [1:0] sel, input logic [31:0] ea,
                      input logic st, input logic rep, input logic [31:0] ra,
                      input logic [15:0] lit, input logic ack);
    exp_t e;
    logic [31:0] np;
    logic ld;
    SysReset = rst; PC_Sel = sel; ExcAddr = ea; Stall = st;
    ReplicatePC = rep; Ra = ra; Lit = lit; ExcAckIF = ack;
    if (!rst) begin
`ifdef PC_SUPERVISOR_BIT_EN
      mPc = 32'h8000_0000;
`else
      mPc = 32'h0;
`endif
      mRr = 0; mEx = 0; mMa = 0; mReq = 0;
    end else begin
      ld = (sel == EX) || !st;
      if (sel == EX) np = ea;
      else if (st) np = mPc;
      else if (sel == LT) np = litTarget(mRr, lit);
      else if (sel == RG) np = jmpTarget(mRr, ra);
      else np = inc4(mPc);
      mMa = mEx;
      mEx = mRr;
      if (!st && (sel == EX || !rep)) mRr = inc4(mPc);
      if (ld) mReq = badAddr(np);
      else if (ack) mReq = 1'b0;
      mPc = np;
    end
    e.pc = mPc; e.rr = mRr; e.ex = mEx; e.ma = mMa; e.req = mReq;
`ifdef PC_SUPERVISOR_BIT_EN
    e.smode = mPc[31];
`else
    e.smode = 1'b0;
`endif
    expQ.push_back(e);
    @(posedge Clock);
    #1;
  endtask

  // Monitor: compare the DUT against the oldest expectation after every edge.
  always @(posedge Clock) begin
    exp_t e;
    #2;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      check("IA", IA, e.pc);
      check("PCInc_RR", PCInc_RR, e.rr);
      check("PCInc_EX", PCInc_EX, e.ex);
      check("PCInc_MA", PCInc_MA, e.ma);
      check("ExcReqIF", {31'b0, ExcReqIF}, {31'b0, e.req});
      check("S_Mode", {31'b0, S_Mode}, {31'b0, e.smode});
      check("ExcCodeIF", {29'b0, ExcCodeIF}, 32'h0);
    end
  end

  initial begin
    logic [31:0] a, r;
    #1;
    step(0, EX, 0, 0, 0, 0, 0, 0);
    step(0, EX, 0, 0, 0, 0, 0, 0);
    // Reset vector then sequential fetch
    step(1, EX, 32'h8000_0000, 0, 0, 0, 0, 0);
    repeat (6) step(1, NX, 0, 0, 0, 0, 0, 0);
    // Branch with ReplicatePC
    step(1, EX, 32'h0000_00FC, 0, 0, 0, 0, 0);
    step(1, NX, 0, 0, 0, 0, 0, 0);
    step(1, LT, 0, 0, 1, 0, 16'hFFFE, 0);
    step(1, NX, 0, 0, 0, 0, 0, 0);
    // JMP from user and supervisor
    step(1, EX, 32'h0000_000C, 0, 0, 0, 0, 0);
    step(1, NX, 0, 0, 0, 0, 0, 0);
    step(1, RG, 0, 0, 0, 32'h8000_0203, 0, 0);
    step(1, EX, 32'h8000_000C, 0, 0, 0, 0, 0);
    step(1, NX, 0, 0, 0, 0, 0, 0);
    step(1, RG, 0, 0, 0, 32'h8000_0203, 0, 0);
    // Stall hold, then stall together with exception vector
    step(1, EX, 32'h0000_003C, 0, 0, 0, 0, 0);
    step(1, NX, 0, 0, 0, 0, 0, 0);
    step(1, NX, 0, 1, 0, 0, 0, 0);
    step(1, NX, 0, 1, 0, 0, 0, 0);
    step(1, EX, 32'h8000_0008, 1, 0, 0, 0, 0);
    step(1, NX, 0, 0, 0, 0, 0, 0);
    // Misaligned fetch: request holds across stall, clears on ack
    step(1, EX, 32'h0000_0006, 0, 0, 0, 0, 0);
    step(1, NX, 0, 1, 0, 0, 0, 0);
    step(1, NX, 0, 1, 0, 0, 0, 0);
    step(1, NX, 0, 1, 0, 0, 0, 1);
    step(1, NX, 0, 1, 0, 0, 0, 0);
    // Ack coinciding with an out-of-range load, then JMP with low bits set
    step(1, EX, 32'h0000_4000, 0, 0, 0, 0, 1);
    step(1, EX, 32'h0000_3FFC, 0, 0, 0, 0, 1);
    step(1, RG, 0, 0, 0, 32'h0000_0006, 0, 0);
    // Bit-31 wrap of the increment
    step(1, EX, 32'h7FFF_FFF8, 0, 0, 0, 0, 0);
    step(1, NX, 0, 0, 0, 0, 0, 0);
    step(1, NX, 0, 0, 0, 0, 0, 0);
    // Reset while stalled with a request pending
    step(1, EX, 32'h0000_0006, 0, 0, 0, 0, 0);
    step(1, NX, 0, 1, 0, 0, 0, 0);
    step(0, NX, 0, 1, 1, 0, 0, 0);
    step(1, EX, 32'h8000_0000, 0, 0, 0, 0, 0);
    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 1) ? 32'h8000_0000 : 32'h0) | (32'($urandom_range(0, 4200)) << 2);
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      r = ($urandom_range(0, 1) ? 32'h8000_0000 : 32'h0) | 32'($urandom_range(0, 17000));
      step($urandom_range(0, 40) != 0, 2'($urandom_range(0, 3)), a,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, r,
           16'($urandom), $urandom_range(0, 2) == 0);
    end
    @(posedge Clock);
    #4;
    check("queue_drained", 32'(expQ.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
